// File: rtl/if_stage.sv
// Instruction-fetch stage: PC sequencing, variable-latency instruction memory handshake,
// load-use hold via a one-word skid buffer, and branch/jump redirect with response discard.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_IR   = 32'h00000020
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ifid_ir,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] drop_addr_reg, drop_addr_next;
    logic [31:0] skid_reg, skid_next;
    logic [31:0] ir_reg, ir_next;
    logic [31:0] pc4_reg, pc4_next;
    logic        valid_reg, valid_next;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_target;

    assign pc_plus4        = pc_reg + 32'd4;
    assign redirect_target = redirect_pc & ~32'd3;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: state_next = REQ;
            REQ: begin
                if (redirect) begin
                    state_next = imem_ready ? REQ : DROP;
                end else if (imem_ready) begin
                    state_next = stall ? HOLD : REQ;
                end
            end
            HOLD: begin
                if (redirect || !stall) begin
                    state_next = REQ;
                end
            end
            DROP: begin
                // A second redirect keeps discarding the original outstanding request.
                if (redirect) begin
                    state_next = DROP;
                end else if (imem_ready) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        imem_req  = (state_reg == REQ) || (state_reg == DROP);
        imem_addr = (state_reg == DROP) ? drop_addr_reg : pc_reg;
    end

    always_comb begin
        pc_next        = pc_reg;
        drop_addr_next = drop_addr_reg;
        skid_next      = skid_reg;
        ir_next        = ir_reg;
        pc4_next       = pc4_reg;
        valid_next     = valid_reg;

        if (state_reg != IDLE && redirect) begin
            pc_next    = redirect_target;
            ir_next    = NOP_IR;
            valid_next = 1'b0;
            skid_next  = '0;
            if (state_reg == REQ && !imem_ready) begin
                drop_addr_next = pc_reg;
            end
        end else begin
            unique case (state_reg)
                REQ: begin
                    if (imem_ready) begin
                        if (!stall) begin
                            ir_next    = imem_rdata;
                            pc4_next   = pc_plus4;
                            valid_next = 1'b1;
                            pc_next    = pc_plus4;
                        end else begin
                            skid_next = imem_rdata;
                        end
                    end else if (!stall) begin
                        ir_next    = NOP_IR;
                        valid_next = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ir_next    = skid_reg;
                        pc4_next   = pc_plus4;
                        valid_next = 1'b1;
                        pc_next    = pc_plus4;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_reg        <= RESET_PC & ~32'd3;
            drop_addr_reg <= '0;
            skid_reg      <= '0;
            ir_reg        <= NOP_IR;
            pc4_reg       <= '0;
            valid_reg     <= 1'b0;
        end else begin
            pc_reg        <= pc_next;
            drop_addr_reg <= drop_addr_next;
            skid_reg      <= skid_next;
            ir_reg        <= ir_next;
            pc4_reg       <= pc4_next;
            valid_reg     <= valid_next;
        end
    end

    assign ifid_ir    = ir_reg;
    assign ifid_pc4   = pc4_reg;
    assign ifid_valid = valid_reg;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized traffic
// compared against a fetch-level reference model.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h00000020;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] ifid_ir;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;

    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic [31:0] w_ifid_ir;
    logic [31:0] w_ifid_pc4;
    logic        w_ifid_valid;

    always #5 clock = ~clock;

    if_stage #(.RESET_PC(32'h00000000), .NOP_IR(NOP)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .ifid_ir(ifid_ir), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid)
    );

    if_stage #(.RESET_PC(32'hFFFFFFFC), .NOP_IR(NOP)) u_wrap (
        .clock(clock), .reset_n(reset_n),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .ifid_ir(w_ifid_ir), .ifid_pc4(w_ifid_pc4), .ifid_valid(w_ifid_valid)
    );

    int total = 0;
    int bad = 0;
    bit mem_mode = 1'b0;
    logic [31:0] last_rdata = '0;

    logic [97:0] dut_view;
    assign dut_view = {imem_req, imem_addr, ifid_ir, ifid_pc4, ifid_valid};

    // Reference model: a fetch pipeline described as "started / holding a buffered word /
    // discarding an abandoned response" rather than as a state machine.
    bit          m_started, m_buffered, m_discarding, m_accept;
    logic [31:0] m_pc, m_old, m_buf, m_ir, m_pc4;
    logic        m_valid;

    task automatic model_reset();
        m_started = 0; m_buffered = 0; m_discarding = 0; m_accept = 0;
        m_pc = 32'h0; m_old = 32'h0; m_buf = 32'h0;
        m_ir = NOP; m_pc4 = 32'h0; m_valid = 1'b0;
    endtask

    task automatic model_step(input logic st, input logic rd, input logic [31:0] rpc,
                              input logic rdy, input logic [31:0] rdat);
        m_accept = 0;
        if (!m_started) begin
            m_started = 1;
        end else if (rd) begin
            if (!m_buffered && !m_discarding && !rdy) begin
                m_discarding = 1;
                m_old = m_pc;
            end
            m_buffered = 0;
            m_pc = {rpc[31:2], 2'b00};
            m_ir = NOP;
            m_valid = 1'b0;
        end else if (m_buffered) begin
            if (!st) begin
                m_ir = m_buf; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
                m_pc = m_pc + 32'd4; m_buffered = 0; m_accept = 1;
            end
        end else if (m_discarding) begin
            if (rdy) m_discarding = 0;
        end else if (rdy) begin
            if (!st) begin
                m_ir = rdat; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
                m_pc = m_pc + 32'd4; m_accept = 1;
            end else begin
                m_buf = rdat; m_buffered = 1;
            end
        end else if (!st) begin
            m_ir = NOP;
            m_valid = 1'b0;
        end
    endtask

    function automatic logic [97:0] model_view();
        return {m_started && !m_buffered, m_discarding ? m_old : m_pc, m_ir, m_pc4, m_valid};
    endfunction

    // Drives one clock of stimulus and leaves the bench at the following falling edge.
    task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc, input logic rdy);
        stall = st; redirect = rd; redirect_pc = rpc; imem_ready = rdy;
        imem_rdata = mem_mode ? (imem_addr >> 2) : $urandom;
        last_rdata = imem_rdata;
        model_step(st, rd, rpc, rdy, imem_rdata);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        stall = 0; redirect = 0; redirect_pc = '0; imem_ready = 0;
        model_reset();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (dut_view !== {1'b0, 32'h0, NOP, 32'h0, 1'b0}) begin
            bad++; $display("FAIL reset_state got=%h want=%h", dut_view, {1'b0, 32'h0, NOP, 32'h0, 1'b0});
        end
        cycle(0, 1, 32'h500, 1);
        total++;
        if (dut_view !== model_view()) begin
            bad++; $display("FAIL idle_exit got=%h want=%h", dut_view, model_view());
        end
        $display("test_reset: done");
    endtask

    task automatic test_sequential();
        logic [31:0] exp_ir;
        do_reset();
        mem_mode = 1;
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 0, 1);
            exp_ir = i;
            total++;
            if (ifid_ir !== exp_ir || ifid_pc4 !== 4 * (exp_ir + 1) || ifid_valid !== 1'b1) begin
                bad++; $display("FAIL seq_word%0d got ir=%h pc4=%h v=%b want ir=%h pc4=%h v=1",
                                i, ifid_ir, ifid_pc4, ifid_valid, exp_ir, 4 * (exp_ir + 1));
            end
            $display("seq: ir=%h pc4=%h", ifid_ir, ifid_pc4);
        end
        total++;
        if (dut_view !== model_view()) begin
            bad++; $display("FAIL seq_model got=%h want=%h", dut_view, model_view());
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        mem_mode = 1;
        cycle(0, 0, 0, 1);
        repeat (2) cycle(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0);
            total++;
            if (ifid_ir !== NOP || ifid_valid !== 1'b0 || imem_addr !== 32'd8 || imem_req !== 1'b1) begin
                bad++; $display("FAIL wait_bubble%0d got ir=%h v=%b addr=%h want ir=%h v=0 addr=8",
                                i, ifid_ir, ifid_valid, imem_addr, NOP);
            end
        end
        cycle(0, 0, 0, 1);
        total++;
        if (ifid_ir !== 32'd2 || ifid_pc4 !== 32'd12 || ifid_valid !== 1'b1) begin
            bad++; $display("FAIL wait_word got ir=%h pc4=%h v=%b want ir=2 pc4=c v=1",
                            ifid_ir, ifid_pc4, ifid_valid);
        end
        $display("wait: ir=%h pc4=%h", ifid_ir, ifid_pc4);
    endtask

    task automatic test_stall_hold();
        do_reset();
        mem_mode = 1;
        cycle(0, 0, 0, 1);
        repeat (4) cycle(0, 0, 0, 1);
        for (int i = 0; i < 2; i++) begin
            cycle(1, 0, 0, 1);
            total++;
            if (ifid_ir !== 32'd3 || ifid_pc4 !== 32'd16 || ifid_valid !== 1'b1 || imem_req !== 1'b0) begin
                bad++; $display("FAIL stall_hold%0d got ir=%h pc4=%h v=%b req=%b want ir=3 pc4=10 v=1 req=0",
                                i, ifid_ir, ifid_pc4, ifid_valid, imem_req);
            end
        end
        cycle(0, 0, 0, 0);
        total++;
        if (ifid_ir !== 32'd4 || ifid_pc4 !== 32'd20 || ifid_valid !== 1'b1 ||
            imem_addr !== 32'd20 || imem_req !== 1'b1) begin
            bad++; $display("FAIL stall_release got ir=%h pc4=%h v=%b addr=%h want ir=4 pc4=14 v=1 addr=14",
                            ifid_ir, ifid_pc4, ifid_valid, imem_addr);
        end
        $display("stall: ir=%h pc4=%h", ifid_ir, ifid_pc4);
    endtask

    task automatic test_redirect_wait();
        do_reset();
        mem_mode = 1;
        cycle(0, 0, 0, 1);
        repeat (6) cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 32'h103, 0);
        total++;
        if (ifid_ir !== NOP || ifid_valid !== 1'b0 || imem_addr !== 32'd24 || imem_req !== 1'b1) begin
            bad++; $display("FAIL redir_flush got ir=%h v=%b addr=%h want ir=%h v=0 addr=18",
                            ifid_ir, ifid_valid, imem_addr, NOP);
        end
        cycle(0, 0, 0, 0);
        total++;
        if (imem_addr !== 32'd24 || ifid_valid !== 1'b0) begin
            bad++; $display("FAIL redir_drop_addr got addr=%h v=%b want addr=18 v=0", imem_addr, ifid_valid);
        end
        cycle(0, 0, 0, 1);
        total++;
        if (imem_addr !== 32'h100 || ifid_valid !== 1'b0 || ifid_ir !== NOP) begin
            bad++; $display("FAIL redir_discard got addr=%h ir=%h v=%b want addr=100 ir=%h v=0",
                            imem_addr, ifid_ir, ifid_valid, NOP);
        end
        cycle(0, 0, 0, 1);
        total++;
        if (ifid_ir !== 32'h40 || ifid_pc4 !== 32'h104 || ifid_valid !== 1'b1) begin
            bad++; $display("FAIL redir_target got ir=%h pc4=%h v=%b want ir=40 pc4=104 v=1",
                            ifid_ir, ifid_pc4, ifid_valid);
        end
        $display("redirect: ir=%h pc4=%h", ifid_ir, ifid_pc4);
    endtask

    task automatic test_redirect_stall();
        do_reset();
        mem_mode = 1;
        cycle(0, 0, 0, 1);
        repeat (2) cycle(0, 0, 0, 1);
        cycle(1, 1, 32'h200, 1);
        total++;
        if (ifid_valid !== 1'b0 || ifid_ir !== NOP || imem_addr !== 32'h200 || imem_req !== 1'b1) begin
            bad++; $display("FAIL redir_stall_req got v=%b ir=%h addr=%h want v=0 addr=200",
                            ifid_valid, ifid_ir, imem_addr);
        end
        cycle(1, 0, 0, 1);
        cycle(1, 1, 32'h301, 0);
        total++;
        if (ifid_valid !== 1'b0 || imem_addr !== 32'h300 || imem_req !== 1'b1) begin
            bad++; $display("FAIL redir_stall_hold got v=%b addr=%h req=%b want v=0 addr=300 req=1",
                            ifid_valid, imem_addr, imem_req);
        end
        $display("redirect+stall: addr=%h", imem_addr);
    endtask

    task automatic test_reset_pc_wrap();
        do_reset();
        mem_mode = 0;
        total++;
        if (w_imem_addr !== 32'hFFFFFFFC || w_imem_req !== 1'b0) begin
            bad++; $display("FAIL wrap_reset got addr=%h req=%b want addr=fffffffc req=0", w_imem_addr, w_imem_req);
        end
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        total++;
        if (w_ifid_ir !== last_rdata || w_ifid_pc4 !== 32'h0 || w_ifid_valid !== 1'b1 || w_imem_addr !== 32'h0) begin
            bad++; $display("FAIL wrap_fetch got ir=%h pc4=%h v=%b addr=%h want ir=%h pc4=0 v=1 addr=0",
                            w_ifid_ir, w_ifid_pc4, w_ifid_valid, w_imem_addr, last_rdata);
        end
        $display("wrap: ir=%h pc4=%h", w_ifid_ir, w_ifid_pc4);
    endtask

    task automatic test_reset_in_drop();
        do_reset();
        mem_mode = 1;
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 1, 32'h40, 0);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd4) begin
            bad++; $display("FAIL drop_enter got req=%b addr=%h want req=1 addr=4", imem_req, imem_addr);
        end
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || ifid_valid !== 1'b0) begin
            bad++; $display("FAIL drop_async_reset got req=%b addr=%h v=%b want req=0 addr=0 v=0",
                            imem_req, imem_addr, ifid_valid);
        end
        @(negedge clock);
        reset_n = 1'b1;
        cycle(0, 0, 0, 1);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || ifid_valid !== 1'b0) begin
            bad++; $display("FAIL drop_restart got req=%b addr=%h v=%b want req=1 addr=0 v=0",
                            imem_req, imem_addr, ifid_valid);
        end
        cycle(0, 0, 0, 1);
        total++;
        if (ifid_ir !== 32'h0 || ifid_pc4 !== 32'd4 || ifid_valid !== 1'b1) begin
            bad++; $display("FAIL drop_first_word got ir=%h pc4=%h v=%b want ir=0 pc4=4 v=1",
                            ifid_ir, ifid_pc4, ifid_valid);
        end
        $display("reset-in-drop: ir=%h pc4=%h", ifid_ir, ifid_pc4);
    endtask

    task automatic test_random();
        logic        st, rd, rdy;
        logic [31:0] rpc;
        do_reset();
        mem_mode = 0;
        for (int i = 0; i < 600; i++) begin
            st  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFD : $urandom;
            cycle(st, rd, rpc, rdy);
            total++;
            if (dut_view !== model_view()) begin
                bad++; $display("FAIL rnd_cycle%0d got=%h want=%h", i, dut_view, model_view());
            end
            if (m_accept) $display("rnd %0d: ir=%h pc4=%h", i, ifid_ir, ifid_pc4);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sequential();
        test_wait_states();
        test_stall_hold();
        test_redirect_wait();
        test_redirect_stall();
        test_reset_pc_wrap();
        test_reset_in_drop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
